// File: rtl/mk_network_simple_if.sv
// Method-level signal bundle between user endpoints and the 2x2 network.
// Signal names match the generated network wrapper so existing endpoints bind unchanged.
interface mk_network_simple_if;
    localparam int unsigned FLIT_W  = 36;
    localparam int unsigned NUM_VCS = 2;

    logic [FLIT_W-1:0]  send_ports_0_putFlit_flit_in;
    logic               EN_send_ports_0_putFlit;
    logic               EN_send_ports_0_getNonFullVCs;
    logic [NUM_VCS-1:0] send_ports_0_getNonFullVCs;
    logic [FLIT_W-1:0]  send_ports_1_putFlit_flit_in;
    logic               EN_send_ports_1_putFlit;
    logic               EN_send_ports_1_getNonFullVCs;
    logic [NUM_VCS-1:0] send_ports_1_getNonFullVCs;

    logic               EN_recv_ports_0_getFlit;
    logic [FLIT_W-1:0]  recv_ports_0_getFlit;
    logic [NUM_VCS-1:0] recv_ports_0_putNonFullVCs_nonFullVCs;
    logic               EN_recv_ports_0_putNonFullVCs;
    logic               EN_recv_ports_1_getFlit;
    logic [FLIT_W-1:0]  recv_ports_1_getFlit;
    logic [NUM_VCS-1:0] recv_ports_1_putNonFullVCs_nonFullVCs;
    logic               EN_recv_ports_1_putNonFullVCs;

    modport master (
        output send_ports_0_putFlit_flit_in, EN_send_ports_0_putFlit, EN_send_ports_0_getNonFullVCs,
        output send_ports_1_putFlit_flit_in, EN_send_ports_1_putFlit, EN_send_ports_1_getNonFullVCs,
        input  send_ports_0_getNonFullVCs, send_ports_1_getNonFullVCs,
        output EN_recv_ports_0_getFlit, recv_ports_0_putNonFullVCs_nonFullVCs, EN_recv_ports_0_putNonFullVCs,
        output EN_recv_ports_1_getFlit, recv_ports_1_putNonFullVCs_nonFullVCs, EN_recv_ports_1_putNonFullVCs,
        input  recv_ports_0_getFlit, recv_ports_1_getFlit
    );

    modport slave (
        input  send_ports_0_putFlit_flit_in, EN_send_ports_0_putFlit, EN_send_ports_0_getNonFullVCs,
        input  send_ports_1_putFlit_flit_in, EN_send_ports_1_putFlit, EN_send_ports_1_getNonFullVCs,
        output send_ports_0_getNonFullVCs, send_ports_1_getNonFullVCs,
        input  EN_recv_ports_0_getFlit, recv_ports_0_putNonFullVCs_nonFullVCs, EN_recv_ports_0_putNonFullVCs,
        input  EN_recv_ports_1_getFlit, recv_ports_1_putNonFullVCs_nonFullVCs, EN_recv_ports_1_putNonFullVCs,
        output recv_ports_0_getFlit, recv_ports_1_getFlit
    );
endinterface

// File: rtl/mk_network_simple.sv
// 2x2 input-buffered virtual-channel wormhole router with separable round-robin allocation.
// Flit: valid, tail, dest, vc, data (MSB to LSB); receivers advertise free VCs via a latched mask.
module mk_network_simple (
    input logic             CLK,
    input logic             RST_N,
    mk_network_simple_if.slave net
);
    localparam int unsigned FLIT_DATA_WIDTH   = 32;
    localparam int unsigned NUM_VCS           = 2;
    localparam int unsigned FLIT_BUFFER_DEPTH = 4;
    localparam int unsigned NUM_PORTS         = 2;
    localparam int unsigned VC_BITS           = 1;
    localparam int unsigned DEST_BITS         = 1;
    localparam int unsigned FLIT_W            = 2 + FLIT_DATA_WIDTH + DEST_BITS + VC_BITS;
    localparam int unsigned PTR_BITS          = 2;
    localparam int unsigned CNT_BITS          = 3;
    localparam int unsigned VALID_B           = FLIT_W - 1;
    localparam int unsigned TAIL_B            = FLIT_W - 2;
    localparam int unsigned DEST_LSB          = FLIT_DATA_WIDTH + VC_BITS;
    localparam int unsigned VC_LSB            = FLIT_DATA_WIDTH;

    function automatic logic [VC_BITS-1:0] vc_add(input logic [VC_BITS-1:0] p, input int k);
        return VC_BITS'((int'(p) + k) % int'(NUM_VCS));
    endfunction

    function automatic logic [DEST_BITS-1:0] port_add(input logic [DEST_BITS-1:0] p, input int k);
        return DEST_BITS'((int'(p) + k) % int'(NUM_PORTS));
    endfunction

    logic                 put_en   [NUM_PORTS];
    logic [FLIT_W-1:0]    put_flit [NUM_PORTS];
    logic                 get_en   [NUM_PORTS];
    logic                 mask_en  [NUM_PORTS];
    logic [NUM_VCS-1:0]   mask_in  [NUM_PORTS];
    logic                 unused_method_en;

    logic [FLIT_W-1:0]    buf_q    [NUM_PORTS][NUM_VCS][FLIT_BUFFER_DEPTH];
    logic [PTR_BITS-1:0]  rd_q     [NUM_PORTS][NUM_VCS];
    logic [PTR_BITS-1:0]  wr_q     [NUM_PORTS][NUM_VCS];
    logic [CNT_BITS-1:0]  cnt_q    [NUM_PORTS][NUM_VCS];
    logic                 active_q [NUM_PORTS][NUM_VCS];
    logic                 busy_q   [NUM_PORTS][NUM_VCS];
    logic [DEST_BITS-1:0] owner_q  [NUM_PORTS][NUM_VCS];
    logic [VC_BITS-1:0]   in_ptr_q [NUM_PORTS];
    logic [DEST_BITS-1:0] out_ptr_q[NUM_PORTS];
    logic [NUM_VCS-1:0]   mask_q   [NUM_PORTS];
    logic [FLIT_W-1:0]    out_q    [NUM_PORTS];

    logic [FLIT_W-1:0]    head_c       [NUM_PORTS][NUM_VCS];
    logic [DEST_BITS-1:0] dest_c       [NUM_PORTS][NUM_VCS];
    logic                 req_c        [NUM_PORTS][NUM_VCS];
    logic [NUM_VCS-1:0]   nonfull_c    [NUM_PORTS];
    logic                 pick_valid_c [NUM_PORTS];
    logic [VC_BITS-1:0]   pick_vc_c    [NUM_PORTS];
    logic [DEST_BITS-1:0] pick_dest_c  [NUM_PORTS];
    logic [FLIT_W-1:0]    pick_flit_c  [NUM_PORTS];
    logic                 grant_valid_c[NUM_PORTS];
    logic [DEST_BITS-1:0] grant_in_c   [NUM_PORTS];
    logic [FLIT_W-1:0]    grant_flit_c [NUM_PORTS];
    logic                 win_c        [NUM_PORTS];
    logic                 pop_c        [NUM_PORTS][NUM_VCS];
    logic                 push_c       [NUM_PORTS][NUM_VCS];

    assign put_en[0]   = net.EN_send_ports_0_putFlit;
    assign put_en[1]   = net.EN_send_ports_1_putFlit;
    assign put_flit[0] = net.send_ports_0_putFlit_flit_in;
    assign put_flit[1] = net.send_ports_1_putFlit_flit_in;
    assign get_en[0]   = net.EN_recv_ports_0_getFlit;
    assign get_en[1]   = net.EN_recv_ports_1_getFlit;
    assign mask_en[0]  = net.EN_recv_ports_0_putNonFullVCs;
    assign mask_en[1]  = net.EN_recv_ports_1_putNonFullVCs;
    assign mask_in[0]  = net.recv_ports_0_putNonFullVCs_nonFullVCs;
    assign mask_in[1]  = net.recv_ports_1_putNonFullVCs_nonFullVCs;

    // getNonFullVCs is always valid; its method enable carries no information.
    assign unused_method_en = net.EN_send_ports_0_getNonFullVCs | net.EN_send_ports_1_getNonFullVCs;

    assign net.send_ports_0_getNonFullVCs = nonfull_c[0];
    assign net.send_ports_1_getNonFullVCs = nonfull_c[1];
    assign net.recv_ports_0_getFlit       = out_q[0];
    assign net.recv_ports_1_getFlit       = out_q[1];

    // Per (input, VC): head flit can move if it owns/can claim its output VC, has credit and a free slot.
    always_comb begin : eligibility
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                head_c[i][v]    = buf_q[i][v][rd_q[i][v]];
                dest_c[i][v]    = head_c[i][v][DEST_LSB +: DEST_BITS];
                nonfull_c[i][v] = (cnt_q[i][v] != CNT_BITS'(FLIT_BUFFER_DEPTH));
                req_c[i][v]     = (cnt_q[i][v] != '0)
                    && (active_q[i][v]
                        ? (busy_q[dest_c[i][v]][v] && (owner_q[dest_c[i][v]][v] == DEST_BITS'(i)))
                        : !busy_q[dest_c[i][v]][v])
                    && mask_q[dest_c[i][v]][v]
                    && (!out_q[dest_c[i][v]][VALID_B] || get_en[dest_c[i][v]]);
            end
        end
    end

    // Stage 1: one VC per input, round-robin from in_ptr_q.
    always_comb begin : vc_select
        for (int i = 0; i < NUM_PORTS; i++) begin
            pick_valid_c[i] = 1'b0;
            pick_vc_c[i]    = '0;
            for (int k = 0; k < NUM_VCS; k++) begin
                if (!pick_valid_c[i] && req_c[i][vc_add(in_ptr_q[i], k)]) begin
                    pick_valid_c[i] = 1'b1;
                    pick_vc_c[i]    = vc_add(in_ptr_q[i], k);
                end
            end
            pick_dest_c[i] = dest_c[i][pick_vc_c[i]];
            pick_flit_c[i] = head_c[i][pick_vc_c[i]];
        end
    end

    // Stage 2: one input per output, round-robin from out_ptr_q.
    always_comb begin : port_select
        for (int j = 0; j < NUM_PORTS; j++) begin
            grant_valid_c[j] = 1'b0;
            grant_in_c[j]    = '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (!grant_valid_c[j] && pick_valid_c[port_add(out_ptr_q[j], k)]
                    && (pick_dest_c[port_add(out_ptr_q[j], k)] == DEST_BITS'(j))) begin
                    grant_valid_c[j] = 1'b1;
                    grant_in_c[j]    = port_add(out_ptr_q[j], k);
                end
            end
            grant_flit_c[j] = pick_flit_c[grant_in_c[j]];
        end
    end

    // A full FIFO still accepts a push in the cycle it is popped.
    always_comb begin : fifo_ctrl
        for (int i = 0; i < NUM_PORTS; i++) begin
            win_c[i] = 1'b0;
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (grant_valid_c[j] && (grant_in_c[j] == DEST_BITS'(i))) begin
                    win_c[i] = 1'b1;
                end
            end
            for (int v = 0; v < NUM_VCS; v++) begin
                pop_c[i][v]  = win_c[i] && (pick_vc_c[i] == VC_BITS'(v));
                push_c[i][v] = put_en[i] && put_flit[i][VALID_B]
                    && (put_flit[i][VC_LSB +: VC_BITS] == VC_BITS'(v))
                    && (nonfull_c[i][v] || pop_c[i][v]);
            end
        end
    end

    always_ff @(posedge CLK) begin : buffer_write
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (push_c[i][v]) begin
                    buf_q[i][v][wr_q[i][v]] <= put_flit[i];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin : state_update
        if (RST_N) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                for (int v = 0; v < NUM_VCS; v++) begin
                    rd_q[i][v]     <= '0;
                    wr_q[i][v]     <= '0;
                    cnt_q[i][v]    <= '0;
                    active_q[i][v] <= 1'b0;
                    busy_q[i][v]   <= 1'b0;
                    owner_q[i][v]  <= '0;
                end
                in_ptr_q[i]  <= '0;
                out_ptr_q[i] <= '0;
                mask_q[i]    <= '0;
                out_q[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                for (int v = 0; v < NUM_VCS; v++) begin
                    if (push_c[i][v]) wr_q[i][v] <= wr_q[i][v] + PTR_BITS'(1);
                    if (pop_c[i][v])  rd_q[i][v] <= rd_q[i][v] + PTR_BITS'(1);
                    cnt_q[i][v] <= cnt_q[i][v] + CNT_BITS'(push_c[i][v]) - CNT_BITS'(pop_c[i][v]);
                end
                if (win_c[i]) in_ptr_q[i] <= vc_add(pick_vc_c[i], 1);
            end
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (mask_en[j]) mask_q[j] <= mask_in[j];
                if (grant_valid_c[j]) begin
                    out_q[j]     <= grant_flit_c[j];
                    out_ptr_q[j] <= port_add(grant_in_c[j], 1);
                    // Heads claim the output VC; tails (incl. single-flit packets) release it.
                    if (grant_flit_c[j][TAIL_B]) begin
                        active_q[grant_in_c[j]][pick_vc_c[grant_in_c[j]]] <= 1'b0;
                        busy_q[j][pick_vc_c[grant_in_c[j]]]               <= 1'b0;
                    end else if (!active_q[grant_in_c[j]][pick_vc_c[grant_in_c[j]]]) begin
                        active_q[grant_in_c[j]][pick_vc_c[grant_in_c[j]]] <= 1'b1;
                        busy_q[j][pick_vc_c[grant_in_c[j]]]               <= 1'b1;
                        owner_q[j][pick_vc_c[grant_in_c[j]]]              <= grant_in_c[j];
                    end
                end else if (get_en[j]) begin
                    out_q[j] <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mk_network_simple.sv
// Directed cycle-by-cycle vectors for the 2x2 VC router, compared one cycle after each edge.
module tb_mk_network_simple;
    typedef struct {
        logic        rst;
        logic        p0_en;
        logic [35:0] p0_flit;
        logic        p1_en;
        logic [35:0] p1_flit;
        logic [1:0]  get;
        logic        m0_en;
        logic [1:0]  m0;
        logic        m1_en;
        logic [1:0]  m1;
        logic [35:0] exp0;
        logic [35:0] exp1;
        logic [1:0]  nf0;
        logic [1:0]  nf1;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t tbl[$];

    mk_network_simple_if net_if();

    mk_network_simple dut (
        .CLK   (clk),
        .RST_N (rst),
        .net   (net_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic p0e, input logic [35:0] p0f, input logic p1e,
                                input logic [35:0] p1f, input logic [1:0] g,
                                input logic m0e, input logic [1:0] m0, input logic m1e,
                                input logic [1:0] m1, input logic [35:0] e0, input logic [35:0] e1,
                                input logic [1:0] nf0, input logic [1:0] nf1);
        vec_t t;
        t.rst = 1'b0; t.p0_en = p0e; t.p0_flit = p0f; t.p1_en = p1e; t.p1_flit = p1f;
        t.get = g; t.m0_en = m0e; t.m0 = m0; t.m1_en = m1e; t.m1 = m1;
        t.exp0 = e0; t.exp1 = e1; t.nf0 = nf0; t.nf1 = nf1;
        return t;
    endfunction

    // Idle cycle: only the expected outputs vary.
    function automatic vec_t idle(input logic [1:0] g, input logic [35:0] e0, input logic [35:0] e1,
                                  input logic [1:0] nf0);
        return mk(0, 36'h0, 0, 36'h0, g, 0, 2'b00, 0, 2'b00, e0, e1, nf0, 2'b11);
    endfunction

    task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input string nm);
        rst = t.rst;
        net_if.EN_send_ports_0_putFlit       = t.p0_en;
        net_if.send_ports_0_putFlit_flit_in  = t.p0_flit;
        net_if.EN_send_ports_1_putFlit       = t.p1_en;
        net_if.send_ports_1_putFlit_flit_in  = t.p1_flit;
        net_if.EN_recv_ports_0_getFlit       = t.get[0];
        net_if.EN_recv_ports_1_getFlit       = t.get[1];
        net_if.EN_recv_ports_0_putNonFullVCs = t.m0_en;
        net_if.recv_ports_0_putNonFullVCs_nonFullVCs = t.m0;
        net_if.EN_recv_ports_1_putNonFullVCs = t.m1_en;
        net_if.recv_ports_1_putNonFullVCs_nonFullVCs = t.m1;
        @(posedge clk);
        #1;
        check({nm, "_recv0"}, net_if.recv_ports_0_getFlit, t.exp0);
        check({nm, "_recv1"}, net_if.recv_ports_1_getFlit, t.exp1);
        check({nm, "_nonfull0"}, 36'(net_if.send_ports_0_getNonFullVCs), 36'(t.nf0));
        check({nm, "_nonfull1"}, 36'(net_if.send_ports_1_getNonFullVCs), 36'(t.nf1));
    endtask

    initial begin
        vec_t t;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        net_if.EN_send_ports_0_getNonFullVCs = 1'b1;
        net_if.EN_send_ports_1_getNonFullVCs = 1'b1;

        // Packet delivery: port 0 -> recv 1, vc0, one cycle latency per flit.
        tbl.push_back(mk(1, 36'hA0000000A, 0, 36'h0, 2'b11, 0, 2'b00, 0, 2'b00, 36'h0, 36'h0, 2'b11, 2'b11));
        tbl.push_back(mk(1, 36'hE0000000B, 0, 36'h0, 2'b11, 0, 2'b00, 0, 2'b00, 36'h0, 36'hA0000000A, 2'b11, 2'b11));
        tbl.push_back(idle(2'b11, 36'h0, 36'hE0000000B, 2'b11));
        tbl.push_back(idle(2'b11, 36'h0, 36'h0, 2'b11));
        // Backpressure: recv1 mask 0, fill FIFO(0,0), drop the 5th, then drain.
        tbl.push_back(mk(0, 36'h0, 0, 36'h0, 2'b11, 0, 2'b00, 1, 2'b00, 36'h0, 36'h0, 2'b11, 2'b11));
        tbl.push_back(mk(1, 36'hE000000C0, 0, 36'h0, 2'b11, 0, 2'b00, 0, 2'b00, 36'h0, 36'h0, 2'b11, 2'b11));
        tbl.push_back(mk(1, 36'hE000000C1, 0, 36'h0, 2'b11, 0, 2'b00, 0, 2'b00, 36'h0, 36'h0, 2'b11, 2'b11));
        tbl.push_back(mk(1, 36'hE000000C2, 0, 36'h0, 2'b11, 0, 2'b00, 0, 2'b00, 36'h0, 36'h0, 2'b11, 2'b11));
        tbl.push_back(mk(1, 36'hE000000C3, 0, 36'h0, 2'b11, 0, 2'b00, 0, 2'b00, 36'h0, 36'h0, 2'b10, 2'b11));
        tbl.push_back(mk(1, 36'hE000000FF, 0, 36'h0, 2'b11, 0, 2'b00, 0, 2'b00, 36'h0, 36'h0, 2'b10, 2'b11));
        tbl.push_back(mk(0, 36'h0, 0, 36'h0, 2'b11, 0, 2'b00, 1, 2'b01, 36'h0, 36'h0, 2'b10, 2'b11));
        tbl.push_back(idle(2'b11, 36'h0, 36'hE000000C0, 2'b11));
        tbl.push_back(idle(2'b11, 36'h0, 36'hE000000C1, 2'b11));
        tbl.push_back(idle(2'b11, 36'h0, 36'hE000000C2, 2'b11));
        tbl.push_back(idle(2'b11, 36'h0, 36'hE000000C3, 2'b11));
        tbl.push_back(idle(2'b11, 36'h0, 36'h0, 2'b11));
        // Wormhole contention on recv0 vc0: port 0 packet wins, port 1 follows intact.
        tbl.push_back(mk(1, 36'h800000011, 1, 36'h800000021, 2'b11, 0, 2'b00, 0, 2'b00, 36'h0, 36'h0, 2'b11, 2'b11));
        tbl.push_back(mk(1, 36'hC00000012, 1, 36'hC00000022, 2'b11, 0, 2'b00, 0, 2'b00, 36'h800000011, 36'h0, 2'b11, 2'b11));
        tbl.push_back(idle(2'b11, 36'hC00000012, 36'h0, 2'b11));
        tbl.push_back(idle(2'b11, 36'h800000021, 36'h0, 2'b11));
        tbl.push_back(idle(2'b11, 36'hC00000022, 36'h0, 2'b11));
        tbl.push_back(idle(2'b11, 36'h0, 36'h0, 2'b11));
        // VC interleave at recv1: out pointer favours port 1 first, then alternates.
        tbl.push_back(mk(0, 36'h0, 0, 36'h0, 2'b11, 0, 2'b00, 1, 2'b11, 36'h0, 36'h0, 2'b11, 2'b11));
        tbl.push_back(mk(1, 36'hA00000031, 1, 36'hB00000041, 2'b11, 0, 2'b00, 0, 2'b00, 36'h0, 36'h0, 2'b11, 2'b11));
        tbl.push_back(mk(1, 36'hE00000032, 1, 36'hF00000042, 2'b11, 0, 2'b00, 0, 2'b00, 36'h0, 36'hB00000041, 2'b11, 2'b11));
        tbl.push_back(idle(2'b11, 36'h0, 36'hA00000031, 2'b11));
        tbl.push_back(idle(2'b11, 36'h0, 36'hF00000042, 2'b11));
        tbl.push_back(idle(2'b11, 36'h0, 36'hE00000032, 2'b11));
        tbl.push_back(idle(2'b11, 36'h0, 36'h0, 2'b11));
        // Output hold: recv0 not consuming keeps its flit and blocks the next one.
        tbl.push_back(mk(1, 36'hC00000071, 0, 36'h0, 2'b10, 0, 2'b00, 0, 2'b00, 36'h0, 36'h0, 2'b11, 2'b11));
        tbl.push_back(mk(1, 36'hC00000072, 0, 36'h0, 2'b10, 0, 2'b00, 0, 2'b00, 36'hC00000071, 36'h0, 2'b11, 2'b11));
        tbl.push_back(idle(2'b10, 36'hC00000071, 36'h0, 2'b11));
        tbl.push_back(idle(2'b11, 36'hC00000072, 36'h0, 2'b11));
        tbl.push_back(idle(2'b11, 36'h0, 36'h0, 2'b11));

        // Reset with credit strobes active: outputs stay empty, all VCs free.
        for (int c = 0; c < 5; c++) begin
            t = mk(0, 36'h0, 0, 36'h0, 2'b11, 1, 2'b11, 1, 2'b11, 36'h0, 36'h0, 2'b11, 2'b11);
            t.rst = 1'b1;
            apply(t, $sformatf("reset%0d", c));
        end
        apply(mk(0, 36'h0, 0, 36'h0, 2'b11, 1, 2'b01, 1, 2'b01, 36'h0, 36'h0, 2'b11, 2'b11), "first_latch");

        foreach (tbl[k]) apply(tbl[k], $sformatf("v%0d", k));

        // Mid-packet reset: port 0 holds recv0 vc0 and a stranded vc1 flit, both must vanish.
        apply(mk(1, 36'h800000051, 0, 36'h0, 2'b11, 0, 2'b00, 0, 2'b00, 36'h0, 36'h0, 2'b11, 2'b11), "mid_head");
        apply(mk(1, 36'h900000053, 0, 36'h0, 2'b11, 0, 2'b00, 0, 2'b00, 36'h800000051, 36'h0, 2'b11, 2'b11), "mid_stuck");
        t = idle(2'b11, 36'h0, 36'h0, 2'b11);
        t.rst = 1'b1;
        apply(t, "mid_reset");
        apply(mk(0, 36'h0, 0, 36'h0, 2'b11, 1, 2'b11, 0, 2'b00, 36'h0, 36'h0, 2'b11, 2'b11), "mid_latch");
        apply(mk(0, 36'h0, 1, 36'h800000061, 2'b11, 0, 2'b00, 0, 2'b00, 36'h0, 36'h0, 2'b11, 2'b11), "mid_new_head");
        apply(mk(0, 36'h0, 1, 36'hC00000062, 2'b11, 0, 2'b00, 0, 2'b00, 36'h800000061, 36'h0, 2'b11, 2'b11), "mid_new_tail");
        apply(idle(2'b11, 36'hC00000062, 36'h0, 2'b11), "mid_tail_out");
        apply(idle(2'b11, 36'h0, 36'h0, 2'b11), "mid_drained");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
